// File: rtl/period_counter_pkg.sv
// Shared constants for the period counter and the restoring divider it feeds:
// default operand widths, timing defaults, FSM encoding and a width helper.
package period_counter_pkg;

  // Operand widths shared with the divider.
  localparam int M_DEF       = 26;      // dividend / reference-count width
  localparam int N_DEF       = 14;      // divisor / edge-count width

  // Timing defaults, in clk cycles.
  localparam int GATE_DEF    = 2**20;
  localparam int TIMEOUT_DEF = 2**22;

  // Measurement FSM states and their 3-bit encoding.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    GATE  = 3'd2,
    CLOSE = 3'd3,
    HOLD  = 3'd4
  } pc_state_e;

  localparam logic [2:0] ST_IDLE  = IDLE;
  localparam logic [2:0] ST_ARM   = ARM;
  localparam logic [2:0] ST_GATE  = GATE;
  localparam logic [2:0] ST_CLOSE = CLOSE;
  localparam logic [2:0] ST_HOLD  = HOLD;

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/period_counter_edge_sync.sv
// Two-flop synchroniser for the asynchronous measured signal plus one delay
// flop; emits a one-cycle rising-edge strobe from the synchronised copy.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  // sync_pipe[0] = s1, [1] = s2, [2] = s3
  logic [2:0] sync_pipe;

  // Shift the raw input through the synchroniser and delay stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[1:0], d};
  end

  assign rise = sync_pipe[1] & ~sync_pipe[2];

endmodule

// File: rtl/period_counter.sv
// Measures an asynchronous signal over a gate window aligned to its rising
// edges: counts clk cycles (dividend) and whole signal periods (divisor),
// then offers both to the divider through a valid/ready handshake.
module period_counter
  import period_counter_pkg::*;
#(
  parameter int M              = M_DEF,
  parameter int N              = N_DEF,
  parameter int GATE_CYCLES    = GATE_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sig_in,
  output logic [M-1:0] dividend,
  output logic [N-1:0] divisor,
  output logic         valid,
  input  logic         ready,
  output logic         busy,
  output logic         timeout
);

  localparam int GW = cnt_w(GATE_CYCLES);
  localparam int TW = cnt_w(TIMEOUT_CYCLES);

  // Terminal values: each counter stops at its last value and never wraps.
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [TW-1:0] ARM_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [M-1:0]  REF_LAST  = {{(M-1){1'b1}}, 1'b0};  // 2**M-2
  localparam logic [N-1:0]  EDGE_LAST = {{(N-1){1'b1}}, 1'b0};  // 2**N-2

  logic [2:0]    state, state_nxt;
  logic [TW-1:0] arm_tmr;
  logic [GW-1:0] gate_tmr;
  logic [M-1:0]  ref_cnt;
  logic [N-1:0]  edge_cnt;
  logic          rise;
  logic          close_now;
  logic          tmo_set;

  edge_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sig_in),
    .rise  (rise)
  );

  assign busy = (state != ST_IDLE);

  // Next-state decode; a timeout holds its state for the pulse cycle so busy
  // drops on the edge after the pulse rather than with it.
  always_comb begin
    state_nxt = state;
    close_now = 1'b0;
    tmo_set   = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_ARM;
      ST_ARM: begin
        if (timeout)                  state_nxt = ST_IDLE;
        else if (rise)                state_nxt = ST_GATE;
        else if (arm_tmr == ARM_LAST) tmo_set   = 1'b1;
      end
      ST_GATE: begin
        // Saturating edge count wins over timer expiry; a rise on the expiry
        // cycle is counted but does not close the gate.
        if (rise && (edge_cnt == EDGE_LAST)) close_now = 1'b1;
        else if (gate_tmr == GATE_LAST)      state_nxt = ST_CLOSE;
      end
      ST_CLOSE: begin
        if (timeout)                  state_nxt = ST_IDLE;
        else if (rise)                close_now = 1'b1;
        else if (ref_cnt == REF_LAST) tmo_set   = 1'b1;
      end
      ST_HOLD:  if (ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (close_now) state_nxt = ST_HOLD;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Arm timer, gate timer, reference and edge counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_tmr  <= '0;
      gate_tmr <= '0;
      ref_cnt  <= '0;
      edge_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) arm_tmr <= '0;
        ST_ARM: begin
          if (rise) begin
            ref_cnt  <= '0;
            edge_cnt <= '0;
            gate_tmr <= '0;
          end else if (arm_tmr != ARM_LAST) begin
            arm_tmr <= arm_tmr + TW'(1);
          end
        end
        ST_GATE: begin
          ref_cnt <= ref_cnt + M'(1);
          if (gate_tmr != GATE_LAST) gate_tmr <= gate_tmr + GW'(1);
          if (rise)                  edge_cnt <= edge_cnt + N'(1);
        end
        ST_CLOSE: if (ref_cnt != REF_LAST) ref_cnt <= ref_cnt + M'(1);
        default: ;
      endcase
    end
  end

  // Result capture, valid handshake and timeout pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dividend <= '0;
      divisor  <= '0;
      valid    <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      timeout <= tmo_set;
      if (close_now) begin
        // The closing edge itself completes the last period, hence +1.
        dividend <= ref_cnt + M'(1);
        divisor  <= edge_cnt + N'(1);
        valid    <= 1'b1;
      end else if ((state == ST_HOLD) && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_period_counter.sv
// Bench for period_counter: directed and randomized measurements checked
// against a rise-time model of the gate window.
module tb_period_counter;

  localparam int M    = 12;
  localparam int N    = 4;
  localparam int GATE = 100;
  localparam int TMO  = 50;

  logic         clk    = 1'b0;
  logic         rst_n  = 1'b0;
  logic         start  = 1'b0;
  logic         sig_in = 1'b0;
  logic         ready  = 1'b1;
  logic [M-1:0] dividend;
  logic [N-1:0] divisor;
  logic         valid, busy, timeout;

  int n_chk    = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int tmo_seen = 0;

  period_counter #(
    .M              (M),
    .N              (N),
    .GATE_CYCLES    (GATE),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sig_in   (sig_in),
    .dividend (dividend),
    .divisor  (divisor),
    .valid    (valid),
    .ready    (ready),
    .busy     (busy),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (timeout) tmo_seen++;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
  endtask

  // One measurement with periods drawn from [pmin,pmax]. Model: with rise
  // times t[0..], the result closes at the first k where k hits 2**N-1 or
  // t[k]-t[0] exceeds GATE; dividend = t[k]-t[0], divisor = k. Outputs appear
  // two cycles after the rise is sampled.
  task automatic run_meas(input string tag, input int pmin, input int pmax, input bit hold);
    logic wave[$];
    int   t[16];
    int   dly, p, h, k, exp_div, exp_cyc, seen_c;
    wave.delete();
    dly = $urandom_range(1, 15);
    repeat (dly) wave.push_back(1'b0);
    for (int i = 0; i < 16; i++) begin
      p = $urandom_range(pmin, pmax);
      h = p / 2;
      t[i] = wave.size();
      repeat (h)     wave.push_back(1'b1);
      repeat (p - h) wave.push_back(1'b0);
    end
    k = 1;
    while ((k < 2**N - 1) && (t[k] - t[0] <= GATE)) k++;
    exp_div = t[k] - t[0];
    exp_cyc = t[k] + 2;

    ready = !hold;
    do_start();
    seen_c = -1;
    for (int c = 0; c < wave.size() + 40; c++) begin
      @(negedge clk);
      sig_in = (c < wave.size()) ? wave[c] : 1'b0;
      tick();
      if (valid) begin
        seen_c = c;
        break;
      end
    end
    check({tag, "_close_cycle"}, seen_c, exp_cyc);
    check({tag, "_dividend"}, dividend, exp_div);
    check({tag, "_divisor"}, divisor, k);
    check({tag, "_busy_hold"}, busy, 1'b1);
    @(negedge clk);
    sig_in = 1'b0;
    if (!hold) begin
      tick();
      check({tag, "_valid_drop"}, valid, 1'b0);
      check({tag, "_busy_drop"}, busy, 1'b0);
    end else begin
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        start = (c == 5);
        tick();
        check({tag, "_frozen"}, {valid, busy, dividend, divisor},
              {1'b1, 1'b1, exp_div[M-1:0], k[N-1:0]});
      end
      start = 1'b0;
      @(negedge clk);
      ready = 1'b1;
      tick();
      check({tag, "_valid_release"}, valid, 1'b0);
      check({tag, "_busy_release"}, busy, 1'b0);
      tick();
      check({tag, "_start_ignored"}, busy, 1'b0);
    end
  endtask

  initial begin
    int seen_c, dly, snap;
    logic wave[$];

    // Reset state
    repeat (3) tick();
    check("rst_valid", valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_dividend", dividend, 0);
    check("rst_divisor", divisor, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_busy", busy, 1'b0);

    // Directed periods
    run_meas("p10", 10, 10, 1'b0);
    run_meas("p7", 7, 7, 1'b0);
    run_meas("p3_sat", 3, 3, 1'b0);

    // Randomized periods, including saturating and jittered cases
    for (int i = 0; i < 8; i++) run_meas("rnd", 2, 25, 1'b0);

    // Backpressure with start pulsed during hold
    run_meas("bp", 4, 20, 1'b1);

    // ARM timeout: signal held low
    sig_in = 1'b0;
    do_start();
    seen_c = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      sig_in = 1'b0;
      tick();
      if (timeout) begin
        seen_c = c;
        break;
      end
    end
    check("arm_tmo_cycle", seen_c, TMO);
    check("arm_tmo_busy_during", busy, 1'b1);
    check("arm_tmo_valid", valid, 1'b0);
    tick();
    check("arm_tmo_pulse_width", timeout, 1'b0);
    check("arm_tmo_busy_after", busy, 1'b0);

    // CLOSE timeout: rises stop exactly at gate expiry, none after
    wave.delete();
    dly = $urandom_range(1, 10);
    repeat (dly) wave.push_back(1'b0);
    for (int i = 0; i <= GATE / 10; i++) begin
      repeat (5) wave.push_back(1'b1);
      repeat (5) wave.push_back(1'b0);
    end
    do_start();
    seen_c = -1;
    for (int c = 0; c < 4400; c++) begin
      @(negedge clk);
      sig_in = (c < wave.size()) ? wave[c] : 1'b0;
      tick();
      if (timeout || valid) begin
        seen_c = c;
        break;
      end
    end
    check("close_tmo_cycle", seen_c, dly + 2 + 2**M - 1);
    check("close_tmo_valid", valid, 1'b0);
    tick();
    check("close_tmo_pulse_width", timeout, 1'b0);
    check("close_tmo_busy_after", busy, 1'b0);

    // Reset mid-GATE
    do_start();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      sig_in = ((c % 5) < 2);
      tick();
    end
    check("pre_rst_busy", busy, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    snap = tmo_seen;
    check("midrst_outputs", {valid, busy, timeout, dividend, divisor}, 0);
    sig_in = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) tick();
    check("midrst_no_timeout", tmo_seen, snap);
    check("midrst_idle", busy, 1'b0);
    run_meas("after_rst", 2, 25, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/period_counter.md
# period_counter

Upstream operand generator for the restoring divider. It measures an asynchronous input signal over a gate window aligned to the signal's rising edges. It counts reference-clock cycles as the dividend (M bits) and whole signal periods as the divisor (N bits), then presents both to the divider with a valid/ready handshake. The divider's quotient is the average signal period in `clk` cycles.

## Interface
- `M`, 26, dividend / reference-count width
- `N`, 14, divisor / edge-count width
- `GATE_CYCLES`, 2**20, nominal gate length in `clk` cycles; must be ≥2 and < 2**M
- `TIMEOUT_CYCLES`, 2**22, maximum wait for the opening edge; must be ≥2

- `clk`  in  1  single clock; all logic is on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  single-cycle request to begin a measurement; honoured only in IDLE
- `sig_in`  in  1  asynchronous measured signal
- `dividend`  out  M  captured reference-cycle count
- `divisor`  out  N  captured period count
- `valid`  out  1  `dividend`/`divisor` are valid and held stable
- `ready`  in  1  consumer accepts the result; tie high if there is no backpressure
- `busy`  out  1  state is not IDLE
- `timeout`  out  1  one-cycle pulse when a measurement is aborted

## Operation
- **Input conditioning:** `sig_in` passes through a 2-flop synchroniser plus one delay flop (s1, s2, s3). The rising-edge event is `rise = s2 & ~s3`.
- **IDLE:** on `start`, go to ARM and clear `arm_tmr`.
- **ARM:** wait for the opening `rise`.
  - On `rise`: `ref_cnt`, `edge_cnt` and `gate_tmr` all become 0; go to GATE.
  - If `arm_tmr == TIMEOUT_CYCLES-1` without a `rise`: pulse `timeout`, go to IDLE.
- **GATE:** every cycle `ref_cnt++` and `gate_tmr++`. On each `rise`, `edge_cnt++`.
  - If `rise` and `edge_cnt+1 == 2**N-1`: close immediately (saturation).
  - Else if `gate_tmr == GATE_CYCLES-1`: go to CLOSE. A `rise` in that same cycle is counted and does not close the gate.
- **CLOSE:** `ref_cnt++` every cycle. The next `rise` closes the gate.
  - If `ref_cnt == 2**M-2` with no `rise`: pulse `timeout`, go to IDLE.
- **Close action:** `dividend <= ref_cnt+1`, `divisor <= edge_cnt+1`, `valid <= 1`, go to HOLD.
  - Result: k whole periods of P cycles give `dividend = k*P` and `divisor = k`.
- **HOLD:** outputs are frozen while `valid` is high. `valid & ready` returns the block to IDLE and deasserts `valid` on the next edge.
- **Counter widths:**
  - `ref_cnt` is M bits; `gate_tmr` is ceil(log2(GATE_CYCLES)) bits; `edge_cnt` is N bits.
  - None of these counters ever wraps.
- **Start handling:** `start` is ignored while `busy`, including in the cycle `valid & ready` fires. The next `start` is honoured one cycle after the return to IDLE.

## Timing
- **Reset:** asynchronous assertion.
  - All outputs are 0 during and after reset: `dividend`, `divisor`, `valid`, `busy`, `timeout`.
  - State returns to IDLE; all counters and synchroniser flops are cleared.
  - Reset mid-measurement discards the measurement; no `timeout` pulse is generated.
- **`sig_in` to `rise`:** a `sig_in` rising transition sampled high at edge k gives `rise` high during cycle k+1→k+2. The FSM acts on it at edge k+2, so the measurement latency is constant and cancels out of `dividend`.
- **`busy`:** rises the edge after `start` is accepted; falls the edge after `valid & ready` or after a `timeout` pulse.
- **`valid` vs `busy`:** `valid` rises on the closing edge and stays high for at least one cycle. `busy` remains high throughout HOLD.
- **Minimum measurement duration:** `GATE_CYCLES` plus up to one signal period.

## Structure
- A shared package holds the defaults for M and N, the state enum (IDLE, ARM, GATE, CLOSE, HOLD) and its 3-bit encoding. The divider consumes the same M/N constants.
- One sub-module, `edge_sync`: synchroniser plus rising-edge detector, with ports `clk`, `rst_n`, `d`, `rise`.
- All remaining logic (FSM, counters, output registers) lives in `period_counter`.

## Test plan
- **Basic, period 10:** `GATE_CYCLES=100`, `sig_in` period 10, `ready=1`. Expect the timer to expire on the same edge as the 10th `rise`, that `rise` to be counted, and the gate to close on the next `rise`: `dividend=110`, `divisor=11`, `valid` high 1 cycle.
- **Basic, period 7:** `GATE_CYCLES=100`, `sig_in` period 7. Expect closing at the first `rise` after expiry: `dividend=105`, `divisor=15`.
- **Saturation:** `N=4`, `GATE_CYCLES=100`, period 3. Expect close at the 15th period: `dividend=45`, `divisor=15`, before the timer expires.
- **Timeout:** `TIMEOUT_CYCLES=50`, `sig_in` held low after `start`. Expect a single-cycle `timeout` pulse 50 cycles after entering ARM, `busy` to drop the next cycle, and `valid` never asserted.
- **Backpressure:** `ready=0` for 20 cycles after `valid`, with `start` pulsed during the hold. Expect `valid`, `dividend` and `divisor` unchanged and `start` ignored. On `ready=1` for one cycle, `valid` and `busy` fall on the next edge.
- **Reset mid-GATE:** assert `rst_n=0` asynchronously mid-cycle during GATE. Expect all outputs immediately 0 and no `timeout` pulse. After release, a fresh `start` produces a correct result.
